// File: rtl/rr_arbiter16_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
//   N        : number of requesters
//   IDW      : width of a requester id ($clog2(N))
//   MAX_HOLD : longest grant in cycles before forced revocation
package arb_pkg;
  localparam int N        = 16;
  localparam int IDW      = 4;
  localparam int MAX_HOLD = 15;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [IDW-1:0] arb_id_t;
endpackage

// File: rtl/rr_arbiter16_pick.sv
// Circular priority pick: first set bit of req at or after ptr, wrapping.
//   req_i [N]   : request vector
//   ptr_i [IDW] : search start index
//   id_o  [IDW] : winning index (don't care when any_o=0)
//   any_o       : at least one request set
module rr_pick #(
  parameter int N   = arb_pkg::N,
  parameter int IDW = arb_pkg::IDW
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] id_o,
  output logic           any_o
);
  logic [N-1:0]   rot;
  logic [IDW-1:0] enc;
  logic [IDW:0]   sum;

  // rotate right by ptr so the search start lands on bit 0
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = j + int'(ptr_i);
      if (idx >= N) idx = idx - N;
      rot[j] = req_i[idx];
    end
  end

  // lowest-index-first encode of the rotated vector
  always_comb begin
    enc = '0;
    for (int i = N-1; i >= 0; i--)
      if (rot[i]) enc = IDW'(i);
  end

  // undo the rotation, mod N
  always_comb begin
    sum = {1'b0, enc} + {1'b0, ptr_i};
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    id_o  = sum[IDW-1:0];
    any_o = |req_i;
  end
endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter with hold limit. One grant at a time, registered
// outputs, at least one IDLE cycle between grants.
//   clk, reset  : clock, async active-high reset
//   req [N]     : level request lines
//   release_i   : holder done (only looked at while BUSY)
//   grant [N]   : one-hot grant, zero when idle
//   grant_id    : binary holder index, zero when idle
//   grant_valid : grant active
//   timeout     : one-cycle pulse when a grant was revoked purely by the hold limit
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int N        = arb_pkg::N,
  parameter int IDW      = arb_pkg::IDW,
  parameter int MAX_HOLD = arb_pkg::MAX_HOLD
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           release_i,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           timeout
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t     state_q;
  logic [IDW-1:0] ptr_q;
  logic [HW-1:0]  hold_cnt_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic           grant_valid_q;
  logic           timeout_q;

  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] ptr_d;
  logic           ex_rel, ex_drop, ex_lim;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .id_o  (pick_id),
    .any_o (pick_any)
  );

  always_comb begin
    pick_oh          = '0;
    pick_oh[pick_id] = 1'b1;
    ptr_d   = (grant_id_q == IDW'(N-1)) ? '0 : grant_id_q + 1'b1;
    ex_rel  = release_i;
    ex_drop = ~req[grant_id_q];
    ex_lim  = (hold_cnt_q == HW'(MAX_HOLD-1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q       <= BUSY;
            grant_q       <= pick_oh;
            grant_id_q    <= pick_id;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= '0;
          end
        end
        BUSY: begin
          if (ex_rel || ex_drop || ex_lim) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= ptr_d;
            // a voluntary exit in the same cycle masks the timeout
            timeout_q     <= ex_lim & ~ex_rel & ~ex_drop;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter16.sv
module tb_rr_arbiter16;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic        release_i;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter16 dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .release_i   (release_i),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // full output check: valid, id, one-hot grant derived from id, timeout
  task automatic chk_out(input string tag, input logic v, input logic [3:0] id, input logic to);
    logic [15:0] oh;
    oh = v ? (16'h0001 << id) : 16'h0000;
    chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
    chk({tag, ".id"},    32'(grant_id),    v ? 32'(id) : 32'h0);
    chk({tag, ".grant"}, 32'(grant),       32'(oh));
    chk({tag, ".tmo"},   32'(timeout),     32'(to));
  endtask

  initial begin
    reset = 1'b1; req = '0; release_i = 1'b0;
    tick; tick;
    chk_out("reset", 1'b0, 4'd0, 1'b0);
    reset = 1'b0;

    // single requester, release, then ptr=1 shown by picking 1 from 0x0003
    req = 16'h0001; tick;
    chk_out("single.gnt", 1'b1, 4'd0, 1'b0);
    release_i = 1'b1; tick;
    chk_out("single.rel", 1'b0, 4'd0, 1'b0);
    release_i = 1'b0; req = 16'h0003; tick;
    chk_out("single.ptr1", 1'b1, 4'd1, 1'b0);
    release_i = 1'b1; tick;
    release_i = 1'b0; req = '0; tick;
    chk_out("single.idle", 1'b0, 4'd0, 1'b0);

    // fairness sweep from ptr=0 after a fresh reset
    reset = 1'b1; #2; reset = 1'b0;
    req = 16'hFFFF; release_i = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick; chk_out($sformatf("fair.g%0d", k), 1'b1, 4'(k % 16), 1'b0);
      tick; chk_out($sformatf("fair.i%0d", k), 1'b0, 4'd0, 1'b0);
    end
    release_i = 1'b0; req = '0; tick;   // ptr now 2

    // timeout: 15 grant cycles, pulse, re-grant after one idle
    req = 16'h0010;
    tick; chk_out("tmo.c0", 1'b1, 4'd4, 1'b0);
    for (int c = 1; c < 15; c++) begin
      tick; chk_out($sformatf("tmo.c%0d", c), 1'b1, 4'd4, 1'b0);
    end
    tick; chk_out("tmo.drop", 1'b0, 4'd0, 1'b1);
    tick; chk_out("tmo.regrant", 1'b1, 4'd4, 1'b0);
    req = '0; tick;
    chk_out("tmo.hdrop", 1'b0, 4'd0, 1'b0);   // ptr now 5

    // holder drops request three cycles in
    req = 16'h0100;
    tick; chk_out("drop.g0", 1'b1, 4'd8, 1'b0);
    tick; tick; chk_out("drop.g2", 1'b1, 4'd8, 1'b0);
    req = '0; tick;
    chk_out("drop.end", 1'b0, 4'd0, 1'b0);
    req = 16'h0300; tick;
    chk_out("drop.ptr9", 1'b1, 4'd9, 1'b0);
    release_i = 1'b1; tick;
    release_i = 1'b0; req = '0;               // ptr now 10

    // release coincides with hold limit
    req = 16'h0400;
    tick; chk_out("bnd.g0", 1'b1, 4'd10, 1'b0);
    for (int c = 1; c < 15; c++) tick;
    chk_out("bnd.g14", 1'b1, 4'd10, 1'b0);
    release_i = 1'b1; tick;
    chk_out("bnd.end", 1'b0, 4'd0, 1'b0);
    release_i = 1'b0; req = '0; tick;
    release_i = 1'b1; tick;
    chk_out("bnd.idlerel", 1'b0, 4'd0, 1'b0);
    release_i = 1'b0;                          // ptr now 11

    // search from 11 wraps to 7, then async reset mid-grant
    req = 16'h0080; tick;
    chk_out("rst.g7", 1'b1, 4'd7, 1'b0);
    #2 reset = 1'b1;
    #1 chk_out("rst.async", 1'b0, 4'd0, 1'b0);
    req = 16'hFFFF; tick;
    chk_out("rst.held", 1'b0, 4'd0, 1'b0);
    reset = 1'b0; req = 16'h8001; tick;
    chk_out("rst.ptr0", 1'b1, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter that shares one resource among N requesters, where N defaults to 16.
- Wraps a circular priority pick around a small hold/timeout state machine.
- Outputs a one-hot grant together with its binary id, in the same one-hot/binary shape as the lab decoder and encoder blocks.
- Sits in front of any shared datapath unit whose users raise a request line and drop it, or pulse release, when finished.

Parameters:
- N, 16, number of requesters.
- IDW, 4, width of grant_id; equals $clog2(N).
- MAX_HOLD, 15, maximum consecutive grant cycles before forced revocation; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  request lines, level-sensitive; bit i is requester i.
- release_i  in  1  current holder finished; sampled only in BUSY.
- grant  out  N  one-hot grant; all zero when grant_valid=0.
- grant_id  out  IDW  binary index of the holder; 0 when grant_valid=0.
- grant_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse, high in the cycle after a grant was revoked by MAX_HOLD.

Behaviour:
- Reset state, applied asynchronously:
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant=0, grant_id=0, grant_valid=0, timeout=0.
- All outputs are registered.
- State IDLE:
  - If req≠0, pick the requester per the pick rule below.
  - Next cycle: grant_valid=1, grant_id=pick, grant=1<<pick, hold_cnt=0, state=BUSY.
  - Latency from req sampled high to grant visible is exactly 1 cycle.
  - If req=0, stay in IDLE.
  - release_i is ignored in IDLE.
- Pick rule: first index at or after ptr whose req bit is set, searching circularly (ptr, ptr+1, …, N-1, 0, …, ptr-1).
- State BUSY: exit conditions, evaluated each cycle in this priority order:
  - (a) release_i=1.
  - (b) req[grant_id]=0, i.e. the holder dropped its request.
  - (c) hold_cnt==MAX_HOLD-1.
- On exit:
  - Next cycle: state=IDLE, grant/grant_id/grant_valid cleared.
  - ptr <= grant_id+1 mod N; id N-1 wraps to 0.
  - timeout=1 for that one cycle only if exit was caused solely by (c).
  - A simultaneous (a) or (b) suppresses timeout.
- Otherwise hold_cnt increments and the grant stays stable.
- Grant duration is 1..MAX_HOLD cycles.
- There is at least one IDLE cycle between consecutive grants, including when the same requester is re-granted.
- Requests changing during BUSY have no effect except (b).
- Pulsing reset mid-BUSY drops the grant immediately and discards ptr.
- No grant is produced while reset is high.

Decomposition:
- Package arb_pkg:
  - localparams N, IDW, MAX_HOLD defaults.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - typedef logic [IDW-1:0] arb_id_t.
- Sub-module rr_pick (combinational):
  - Inputs req[N], ptr[IDW].
  - Outputs id[IDW], any.
  - Function: rotate req right by ptr, apply a lowest-index-first priority encode, add ptr back mod N.
  - Independently testable with an exhaustive sweep of ptr × req.
- Top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
- Single requester: after reset, req=16'h0001.
  - Next cycle: grant=16'h0001, grant_id=0, grant_valid=1.
  - Pulse release_i=1 for one cycle: following cycle grant=0, grant_valid=0, timeout=0; internal ptr=1.
- Fairness sweep: req=16'hFFFF held, release_i pulsed on every grant cycle.
  - Grant ids are 0,1,2,…,15,0,1 in that order.
  - Each grant lasts 1 cycle, separated by exactly 1 IDLE cycle.
- Timeout: req=16'h0010 held, release_i=0, MAX_HOLD=15.
  - grant_valid is high exactly 15 consecutive cycles with grant_id=4.
  - timeout=1 for exactly 1 cycle as grant drops.
  - Grant id 4 returns after one IDLE cycle; the circular search starting at ptr=5 wraps back to 4.
- Holder drops request: req=16'h0100 granted, then req goes to 0 three cycles into the grant.
  - Grant drops on the next cycle, timeout stays 0.
  - Then req=16'h0300 yields grant_id=9, since ptr=9.
- Release at the timeout boundary: release_i=1 in the same cycle hold_cnt==MAX_HOLD-1.
  - Grant ends, timeout remains 0.
  - A release_i pulse during IDLE with req=0 produces no state change.
- Asynchronous reset mid-BUSY: grant_id=7 active, assert reset between clock edges.
  - All outputs go to 0 before the next edge.
  - After deassertion with req=16'h8001: grant_id=0 (ptr was reset).
